// File: rtl/ai_ram_reader.sv
// Streaming read master: walks a wrapping address window of ai_ram and re-emits the words on a valid/ready stream.
// Optional abort input enabled by defining AI_RAM_READER_ABORT_EN.
module ai_ram_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef AI_RAM_READER_ABORT_EN
    input  logic                  abort,
`endif
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic [1:0]            state_dbg
);
    // Stream handshake: a word transfers on any edge where m_valid && m_ready;
    // m_valid never drops and m_data/m_last never change until that happens.

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

    localparam logic [ADDR_WIDTH:0]   LEN_ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

    state_t                state_q;
    logic                  busy_q, done_q;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   issued_q, issued_d;
    logic                  inflight_q, inflight_last_q;
    logic [DATA_WIDTH-1:0] fifo_data_q [2];
    logic                  fifo_last_q [2];
    logic                  rd_ptr_q, wr_ptr_q;
    logic [1:0]            count_q, count_d, occ;
    logic                  push, hs, issue, abort_run;

`ifdef AI_RAM_READER_ABORT_EN
    assign abort_run = abort && (state_q == RUN);
`else
    assign abort_run = 1'b0;
`endif

    assign busy      = busy_q;
    assign done      = done_q;
    assign ram_addr  = addr_q;
    assign ram_we    = 1'b0;
    assign ram_din   = '0;
    assign m_valid   = (count_q != 2'd0);
    assign m_data    = fifo_data_q[rd_ptr_q];
    assign m_last    = m_valid && fifo_last_q[rd_ptr_q];
    assign state_dbg = state_q;

    // Occupancy counts the word still inside the RAM, so a handshake frees a slot for same-cycle issue.
    always_comb begin
        push     = (state_q == RUN) && inflight_q;
        hs       = m_valid && m_ready;
        occ      = count_q + {1'b0, inflight_q};
        issue    = (state_q == RUN) && (issued_q < len_q) &&
                   ((occ < 2'd2) || ((occ == 2'd2) && hs));
        addr_d   = addr_q + ADDR_ONE;
        issued_d = issued_q + LEN_ONE;
        count_d  = count_q;
        case ({push, hs})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            addr_q          <= '0;
            len_q           <= '0;
            issued_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            fifo_data_q[0]  <= '0;
            fifo_data_q[1]  <= '0;
            fifo_last_q[0]  <= 1'b0;
            fifo_last_q[1]  <= 1'b0;
            rd_ptr_q        <= 1'b0;
            wr_ptr_q        <= 1'b0;
            count_q         <= 2'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            state_q    <= RUN;
                            busy_q     <= 1'b1;
                            addr_q     <= base_addr;
                            len_q      <= length;
                            issued_q   <= '0;
                            inflight_q <= 1'b0;
                            rd_ptr_q   <= 1'b0;
                            wr_ptr_q   <= 1'b0;
                            count_q    <= 2'd0;
                        end else begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort_run) begin
                        count_q    <= 2'd0;
                        inflight_q <= 1'b0;
                        state_q    <= FIN;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                    end else begin
                        inflight_q <= issue;
                        if (issue) begin
                            addr_q          <= addr_d;
                            issued_q        <= issued_d;
                            inflight_last_q <= (issued_q == len_q - LEN_ONE);
                        end
                        if (push) begin
                            fifo_data_q[wr_ptr_q] <= ram_dout;
                            fifo_last_q[wr_ptr_q] <= inflight_last_q;
                            wr_ptr_q              <= ~wr_ptr_q;
                        end
                        if (hs) begin
                            rd_ptr_q <= ~rd_ptr_q;
                        end
                        count_q <= count_d;
                        if (hs && m_last) begin
                            state_q <= FIN;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ai_ram_reader.sv
// Directed bench for ai_ram_reader: RAM model, stream scoreboard with expected queue, timing and reset checks.
// Abort scenario is compiled in when AI_RAM_READER_ABORT_EN is defined.
module tb_ai_ram_reader;
  localparam int DW = 32;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          busy, done;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout = '0;
  logic          m_valid, m_last;
  logic [DW-1:0] m_data;
  logic          m_ready = 1'b1;
  logic [1:0]    state_dbg;
`ifdef AI_RAM_READER_ABORT_EN
  logic          abort = 1'b0;
`endif

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW:0]   exp_q[$];

  int n_checks = 0;
  int n_fail = 0;
  int hs_cnt = 0;
  logic occ_en = 1'b0;
  logic skip_stab = 1'b0;
  logic [AW-1:0] occ_prev_addr;
  int occ_iss = 0;
  int occ_hs_base = 0;

  ai_ram_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk),
    .rst(rst),
`ifdef AI_RAM_READER_ABORT_EN
    .abort(abort),
`endif
    .start(start),
    .base_addr(base_addr),
    .length(length),
    .busy(busy),
    .done(done),
    .ram_addr(ram_addr),
    .ram_we(ram_we),
    .ram_din(ram_din),
    .ram_dout(ram_dout),
    .m_valid(m_valid),
    .m_data(m_data),
    .m_last(m_last),
    .m_ready(m_ready),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h100 + i;
  end

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic start_cmd(input logic [AW-1:0] b, input logic [AW:0] l);
    logic [AW-1:0] a;
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = b;
    length = l;
    for (int i = 0; i < int'(l); i++) begin
      a = b + AW'(i);
      exp_q.push_back({(i == int'(l) - 1), mem[a]});
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string tag);
    logic seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check(tag, seen, 1);
    check({tag, "_sb_empty"}, exp_q.size(), 0);
  endtask

  // scoreboard / stream monitor
  initial begin
    logic          stall_prev = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    logic [DW:0]   e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        check("ram_we", ram_we, 0);
        if (occ_en) begin
          if (ram_addr != occ_prev_addr) occ_iss++;
          occ_prev_addr = ram_addr;
          check("occupancy_le2", (occ_iss - (hs_cnt - occ_hs_base)) <= 2, 1);
        end
        if (stall_prev && !skip_stab) begin
          check("stall_valid", m_valid, 1);
          check("stall_data", m_data, prev_data);
          check("stall_last", m_last, prev_last);
        end
        if (exp_q.size() == 0) check("spurious_valid", m_valid, 0);
        if (m_valid && m_ready) begin
          hs_cnt++;
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("word_data", m_data, e[DW-1:0]);
            check("word_last", m_last, e[DW]);
          end
        end
        stall_prev = m_valid && !m_ready;
        prev_data = m_data;
        prev_last = m_last;
      end
    end
  end

  // directed sequence
  initial begin
    int hb;
    logic seen;
    logic [AW-1:0] seq [4];

    // reset values
    #3;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", m_valid, 0);
    check("rst_last", m_last, 0);
    check("rst_data", m_data, 0);
    check("rst_addr", ram_addr, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // basic transfer: base 5, length 4
    start_cmd(10'd5, 11'd4);
    @(negedge clk);
    check("t1_busy", busy, 1);
    check("t1_addr0", ram_addr, 5);
    check("t1_valid_e0", m_valid, 0);
    @(negedge clk);
    check("t1_valid_e1", m_valid, 0);
    check("t1_addr1", ram_addr, 6);
    @(negedge clk);
    check("t1_valid_e2", m_valid, 1);
    check("t1_data0", m_data, 32'h105);
    check("t1_last0", m_last, 0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    check("t1_data3", m_data, 32'h108);
    check("t1_last3", m_last, 1);
    @(negedge clk);
    check("t1_done", done, 1);
    check("t1_busy_fin", busy, 0);
    check("t1_valid_fin", m_valid, 0);
    @(negedge clk);
    check("t1_done_pulse", done, 0);
    check("t1_sb_empty", exp_q.size(), 0);

    // address wrap: base 1022, length 4
    seq[0] = 10'd1022; seq[1] = 10'd1023; seq[2] = 10'd0; seq[3] = 10'd1;
    start_cmd(10'd1022, 11'd4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("t2_addr%0d", i), ram_addr, seq[i]);
    end
    wait_done(20, "t2_done");

    // backpressure: length 8, m_ready 1,0,0,1 repeating; stray start while busy
    start_cmd(10'd100, 11'd8);
    occ_prev_addr = ram_addr;
    occ_iss = 0;
    occ_hs_base = hs_cnt;
    occ_en = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 80 && !seen; c++) begin
      m_ready = ((c % 4) == 0) || ((c % 4) == 3);
      if (c == 5) begin
        start = 1'b1;
        base_addr = 10'd0;
        length = 11'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    occ_en = 1'b0;
    start = 1'b0;
    m_ready = 1'b1;
    check("t3_done", seen, 1);
    check("t3_sb_empty", exp_q.size(), 0);
    check("t3_words", hs_cnt - occ_hs_base, 8);
    @(negedge clk);
    check("t3_no_restart", busy, 0);

    // zero length
    start_cmd(10'd7, 11'd0);
    @(negedge clk);
    check("t4_done", done, 1);
    check("t4_busy", busy, 0);
    check("t4_valid", m_valid, 0);
    @(negedge clk);
    check("t4_done_pulse", done, 0);
    check("t4_valid2", m_valid, 0);

    // reset mid-transfer with 3 words pending
    start_cmd(10'd40, 11'd6);
    hb = hs_cnt;
    for (int i = 0; i < 30 && (hs_cnt - hb) < 3; i++) begin
      @(posedge clk); #1;
    end
    check("t5_hs3", hs_cnt - hb, 3);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_valid", m_valid, 0);
    check("t5_last", m_last, 0);
    check("t5_data", m_data, 0);
    check("t5_addr", ram_addr, 0);
    @(negedge clk);
    check("t5_no_done_a", done, 0);
    @(negedge clk);
    check("t5_no_done_b", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    start_cmd(10'd20, 11'd3);
    wait_done(20, "t5_restart_done");

`ifdef AI_RAM_READER_ABORT_EN
    // abort after 2 of 6 words
    start_cmd(10'd60, 11'd6);
    hb = hs_cnt;
    for (int i = 0; i < 30 && (hs_cnt - hb) < 2; i++) begin
      @(posedge clk); #1;
    end
    check("t6_hs2", hs_cnt - hb, 2);
    abort = 1'b1;
    m_ready = 1'b0;
    skip_stab = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("t6_valid", m_valid, 0);
    check("t6_done", done, 1);
    check("t6_last", m_last, 0);
    skip_stab = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    check("t6_done_pulse", done, 0);
`endif

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ai_ram_reader.md
# ai_ram_reader

Streaming read master for the NPU's single-port synchronous `ai_ram`. On a start command it walks a contiguous address window, drives the RAM address and write-enable, and captures the one-cycle-latency read data. It re-emits the words on a valid/ready stream with backpressure and a last-word flag. It sits between weight/activation RAM and the compute array's input FIFO.

## Interface
- `DATA_WIDTH`, 32, RAM word width and stream data width.
- `ADDR_WIDTH`, 10, RAM address width; depth is 2^ADDR_WIDTH.
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle command; sampled only while idle.
- `base_addr`  in  ADDR_WIDTH  first word address; sampled with `start`.
- `length`  in  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH; sampled with `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle completion pulse.
- `ram_addr`  out  ADDR_WIDTH  RAM address.
- `ram_we`  out  1  RAM write enable; constant 0.
- `ram_din`  out  DATA_WIDTH  RAM write data; constant 0.
- `ram_dout`  in  DATA_WIDTH  RAM registered read data.
- `m_valid`  out  1  stream word valid.
- `m_data`  out  DATA_WIDTH  stream word.
- `m_last`  out  1  high with the final word of a transfer.
- `m_ready`  in  1  downstream accept.

## Operation
- Issue:
  - `ram_addr` = `base_addr` + issued count, modulo 2^ADDR_WIDTH; the window wraps past the top address to 0.
  - Each issued address yields exactly one word.
- States:
  - `IDLE`: `busy`=0. On `start` with `length`≠0, latch the command and go to `RUN`. On `start` with `length`=0, go to `FIN`.
  - `RUN`: issue reads, capture words, emit words. When the last word handshakes (`m_valid`&&`m_ready`&&`m_last`), go to `FIN`.
  - `FIN`: `done`=1 for one cycle, `busy`=0, return to `IDLE`.
- Buffering:
  - A 2-entry output FIFO plus a 1-bit in-flight flag.
  - A read issues when issued < `length` and (occupancy + in-flight) < 2, or when the sum is 2 and a stream handshake occurs in the same cycle.
  - An issued read is captured from `ram_dout` on the next edge. The FIFO never overflows.
- Stream rules:
  - `m_data`/`m_last` stay stable while `m_valid`&&!`m_ready`.
  - `m_valid` never drops without a handshake.
  - `m_last` is high only on word number `length`-1.
- Command handling:
  - `start` while `busy` is ignored; it has no effect on the latched command.
- Reset:
  - Clears state to `IDLE` and empties FIFO and in-flight.
  - `busy`=0, `done`=0, `m_valid`=0, `m_last`=0, `m_data`=0, `ram_addr`=0.
  - Reset mid-transfer discards all pending words; no `done` is produced.

## Timing
- `start` is sampled at edge E0.
- `busy`=1 and `ram_addr`=`base_addr` (first issue) in the cycle after E0.
- RAM captures the address at E1. The word is in the FIFO and `m_valid`=1 after E2. First-word latency is 2 cycles from the `start` edge.
- With `m_ready` held high, one word per cycle: a transfer of N words has its last handshake in the cycle after edge E(N+1).
- `done` pulses in the cycle after the last handshake.
- `length`=0: `done` in the cycle after E0; `m_valid` never rises.
- Backpressure: after `m_ready` falls, at most 2 words are buffered and issue stalls. On resume, issue restarts in the same cycle as the first handshake, with no bubble.

## Configuration
- `AI_RAM_READER_ABORT_EN`:
  - Defined: adds input `abort` (1 bit). `abort` in `RUN` flushes the FIFO and in-flight flag, deasserts `m_valid` next cycle, and goes to `FIN` (`done` pulses, no `m_last`). `abort` in `IDLE`/`FIN` is ignored.
  - Undefined: no `abort` port; transfers always run to completion.

## Test plan
- Preload mem[i]=i+0x100. Use `base_addr`=5, `length`=4, `m_ready`=1. Expect 0x105..0x108 on consecutive cycles, first `m_valid` 2 cycles after `start`, `m_last` on 0x108, then `done` one cycle later.
- Use `base_addr`=1022, `length`=4 (ADDR_WIDTH=10). Expect `ram_addr` sequence 1022, 1023, 0, 1 and data from those addresses in order.
- `length`=8 with `m_ready` toggling 1,0,0,1,… Expect all 8 words in order, no duplicates or drops, data stable while stalled, and FIFO occupancy never above 2.
- `length`=0. Expect `done` exactly 1 cycle after `start`, `m_valid` never high, and `ram_we` always 0.
- Assert `rst` mid-transfer with 3 words pending. Expect all outputs at reset values immediately, no `done`, and a following `start` that runs cleanly.
- With ABORT_EN: pulse `abort` after 2 of 6 words. Expect `m_valid` low next cycle, `done` pulse, and no `m_last`.
